ysyx_22041752_mdu: RTL and testbench

//  Iterative, multi-cycle RV64M multiply/divide unit with valid/ready handshakes.

---
 rtl/ysyx_22041752_mdu.sv | 172 +++++++++++++++++
 tb/tb_ysyx_22041752_mdu.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041752_mdu.sv
// Iterative RV64M multiply/divide unit for the EXE stage.
// Multiplication is shift-add over a double-width product; division is restoring,
// one quotient bit per cycle. Signed operations run on magnitudes and fix the sign
// at the end. Division by zero and signed overflow take a one-cycle fast path.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | ready for a request (in_ready=1)
// S_CALC | iterating, cnt counts down to 0 on the last step
// S_DONE | out_result valid, held until out_ready
module ysyx_22041752_mdu #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);

  localparam int HALF = XLEN / 2;
  localparam int DW   = 2 * XLEN;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t state, state_nxt;
  logic   accept;

  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_r;
  logic             word_r, neg1_r, neg2_r;
  logic [DW-1:0]    acc, mc;
  logic [XLEN-1:0]  mr, rem;

  // request decode
  logic            is_div, s1_sgn, s2_sgn, x_neg, y_neg;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] x_ext, y_ext, x_abs, y_abs, min_n, fast_res;

  // iteration step
  logic [DW-1:0]   acc_nxt, mc_nxt, prod;
  logic [XLEN-1:0] mr_nxt, rem_nxt, quo, remv, raw, calc_res;
  logic [XLEN+1:0] div_diff;
  logic            div_msb, q_bit;

  // W results are the low half sign-extended, also for the unsigned divides
  function automatic logic [XLEN-1:0] word_fix(input logic w, input logic [XLEN-1:0] v);
    return w ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : v;
  endfunction

  // operand extension, magnitudes, and fast-path detection for the incoming request
  always_comb begin
    is_div = in_op[2];
    s1_sgn = !(in_op == 3'd3 || in_op == 3'd5 || in_op == 3'd7);
    s2_sgn = s1_sgn && (in_op != 3'd2);
    if (in_word) begin
      x_ext = {{HALF{s1_sgn & in_src1[HALF-1]}}, in_src1[HALF-1:0]};
      y_ext = {{HALF{s2_sgn & in_src2[HALF-1]}}, in_src2[HALF-1:0]};
      min_n = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};
    end else begin
      x_ext = in_src1;
      y_ext = in_src2;
      min_n = {1'b1, {(XLEN-1){1'b0}}};
    end
    x_neg    = s1_sgn & x_ext[XLEN-1];
    y_neg    = s2_sgn & y_ext[XLEN-1];
    x_abs    = x_neg ? -x_ext : x_ext;
    y_abs    = y_neg ? -y_ext : y_ext;
    div_zero = is_div && (y_ext == '0);
    div_ovf  = is_div && s1_sgn && (x_ext == min_n) && (y_ext == '1);
    fast     = div_zero || div_ovf;
    if (div_zero) fast_res = in_op[1] ? x_ext : '1;
    else          fast_res = in_op[1] ? '0 : x_ext;
  end

  // one multiply or divide iteration, plus the result the final step would produce
  always_comb begin
    acc_nxt  = mr[0] ? acc + mc : acc;
    div_msb  = word_r ? mc[HALF-1] : mc[XLEN-1];
    div_diff = {1'b0, rem, div_msb} - {2'b00, mr};
    q_bit    = ~div_diff[XLEN+1];
    rem_nxt  = q_bit ? XLEN'(div_diff) : XLEN'({rem, div_msb});
    if (op_r[2]) begin
      mc_nxt = {mc[DW-1:XLEN], mc[XLEN-2:0], q_bit};
      mr_nxt = mr;
    end else begin
      mc_nxt = mc << 1;
      mr_nxt = mr >> 1;
    end
    prod = (neg1_r ^ neg2_r) ? -acc_nxt : acc_nxt;
    quo  = (neg1_r ^ neg2_r) ? -mc_nxt[XLEN-1:0] : mc_nxt[XLEN-1:0];
    remv = neg1_r ? -rem_nxt : rem_nxt;
    case (op_r)
      3'd0:                raw = prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    raw = prod[DW-1:XLEN];
      3'd4, 3'd5:          raw = quo;
      default:             raw = remv;
    endcase
    calc_res = word_fix(word_r, raw);
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // next state; flush overrides everything, including a request in IDLE
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          accept    = 1'b1;
          state_nxt = fast ? S_DONE : S_CALC;
        end
        S_CALC: if (cnt == '0) state_nxt = S_DONE;
        S_DONE: if (out_ready) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // datapath: latch operands on accept, iterate in CALC, capture result on the last step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      op_r       <= '0;
      word_r     <= 1'b0;
      neg1_r     <= 1'b0;
      neg2_r     <= 1'b0;
      acc        <= '0;
      mc         <= '0;
      mr         <= '0;
      rem        <= '0;
      out_result <= '0;
    end else if (accept) begin
      op_r   <= in_op;
      word_r <= in_word;
      neg1_r <= x_neg;
      neg2_r <= y_neg;
      acc    <= '0;
      mc     <= {{XLEN{1'b0}}, x_abs};
      mr     <= y_abs;
      rem    <= '0;
      cnt    <= in_word ? CNT_W'(HALF - 1) : CNT_W'(XLEN - 1);
      if (fast) out_result <= word_fix(in_word, fast_res);
    end else if (state == S_CALC && !flush) begin
      acc <= acc_nxt;
      mc  <= mc_nxt;
      mr  <= mr_nxt;
      rem <= rem_nxt;
      if (cnt == '0) out_result <= calc_res;
      else           cnt        <= cnt - CNT_W'(1);
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

endmodule

// File: tb/tb_ysyx_22041752_mdu.sv
// Scoreboard bench for ysyx_22041752_mdu: the driver pushes hand-computed results,
// the monitor pops and compares on each out_valid && out_ready.
module tb_ysyx_22041752_mdu;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, in_word, out_valid, out_ready;
  logic [2:0]  in_op;
  logic [63:0] in_src1, in_src2, out_result;

  ysyx_22041752_mdu #(.XLEN(64), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_word(in_word),
    .in_src1(in_src1), .in_src2(in_src2),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          lat;   // cycle offset of out_valid from the accept cycle T
    int          acc;   // edge count at the accept edge
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // monitor: latency at first out_valid, stability while held, result at handshake
  logic seen = 1'b0, chk_rdy = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      seen    <= 1'b0;
      chk_rdy <= 1'b0;
    end else begin
      chk_rdy <= 1'b0;
      if (chk_rdy) check64("in_ready_after_handshake", {63'd0, in_ready}, 64'd1);
      if (out_valid) begin
        if (sb.size() == 0) begin
          check64("spurious_out_valid", {63'd0, out_valid}, 64'd0);
        end else begin
          if (!seen) begin
            seen <= 1'b1;
            check64({sb[0].name, "_latency"}, 64'(cyc - sb[0].acc + 1), 64'(sb[0].lat));
            check64({sb[0].name, "_in_ready_busy"}, {63'd0, in_ready}, 64'd0);
          end
          if (out_ready) begin
            check64(sb[0].name, out_result, sb[0].res);
            void'(sb.pop_front());
            seen    <= 1'b0;
            chk_rdy <= 1'b1;
          end else begin
            check64({sb[0].name, "_hold"}, out_result, sb[0].res);
            check64({sb[0].name, "_hold_in_ready"}, {63'd0, in_ready}, 64'd0);
          end
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input int lat,
                       input string name, input int hold);
    int guard;
    @(negedge clk);
    out_ready = (hold == 0);
    in_op = op; in_word = w; in_src1 = a; in_src2 = b; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 200) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back('{exp, lat, cyc, name});
    if (hold > 0) begin
      guard = 0;
      while (!out_valid && guard < 200) begin @(posedge clk); #1; guard++; end
      repeat (hold) @(posedge clk);
      #1 out_ready = 1'b1;
    end
    guard = 0;
    while (sb.size() != 0 && guard < 300) begin @(negedge clk); guard++; end
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL %s_timeout: result still pending after %0d cycles, want handshake", name, guard);
      sb.delete();
    end
  endtask

  // start a division without expecting a result (used for abort tests)
  task automatic start_raw(output int acc_edge);
    @(negedge clk);
    in_op = 3'd4; in_word = 1'b0; in_src1 = 64'd1000; in_src2 = 64'd7; in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc_edge = cyc;
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    int hi = 0;
    repeat (cycles) begin @(negedge clk); if (out_valid) hi++; end
    check64(name, 64'(hi), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

  initial begin
    int a;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_word = 1'b0;
    in_src1 = '0; in_src2 = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check64("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check64("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check64("reset_out_result", out_result, 64'd0);
    reset = 1'b0;

    // op, word, src1, src2, expected, latency, name, hold
    issue(3'd0, 1'b0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 65, "mul_7_m3", 0);
    issue(3'd3, 1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 65, "mulhu_ones", 10);
    issue(3'd2, 1'b0, ONES, 64'd2, ONES, 65, "mulhsu_m1_2", 0);
    issue(3'd1, 1'b0, 64'h4000_0000_0000_0000, 64'd4, 64'd1, 65, "mulh_pos", 0);
    issue(3'd1, 1'b0, MIN, 64'd2, ONES, 65, "mulh_neg", 0);
    issue(3'd0, 1'b0, 64'd0, 64'd5, 64'd0, 65, "mul_zero_slow", 0);
    issue(3'd4, 1'b0, -64'sd7, 64'd2, -64'sd3, 65, "div_m7_2", 0);
    issue(3'd6, 1'b0, -64'sd7, 64'd2, ONES, 65, "rem_m7_2", 0);
    issue(3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65, "divu_100_7", 0);
    issue(3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 65, "remu_100_7", 0);
    issue(3'd5, 1'b1, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33, "divuw_8000", 0);
    issue(3'd0, 1'b1, 64'hABCD_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, "mulw_wrap", 0);
    issue(3'd6, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, ONES, 33, "remw_m7_2", 0);
    issue(3'd4, 1'b0, 64'd55, 64'd0, ONES, 1, "div_by_zero", 0);
    issue(3'd7, 1'b0, 64'h1234, 64'd0, 64'h1234, 1, "remu_by_zero", 0);
    issue(3'd4, 1'b0, MIN, ONES, MIN, 1, "div_overflow", 0);
    issue(3'd6, 1'b0, MIN, ONES, 64'd0, 1, "rem_overflow", 0);
    issue(3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
          64'hFFFF_FFFF_8000_0000, 1, "divw_overflow", 0);
    issue(3'd7, 1'b1, 64'h0000_0000_8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 1, "remuw_by_zero", 0);

    // flush during cycle T+20 of a DIV
    start_raw(a);
    repeat (19) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check64("flush_in_ready", {63'd0, in_ready}, 64'd1);
    check64("flush_out_valid", {63'd0, out_valid}, 64'd0);
    expect_quiet("flush_no_result", 80);

    // flush together with a request in IDLE: nothing is accepted
    @(negedge clk);
    in_op = 3'd4; in_word = 1'b0; in_src1 = 64'd9; in_src2 = 64'd0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check64("flush_idle_in_ready", {63'd0, in_ready}, 64'd1);
    expect_quiet("flush_idle_no_result", 5);

    // asynchronous reset during cycle T+5
    start_raw(a);
    repeat (4) @(posedge clk);
    #3;
    check64("pre_reset_busy", {63'd0, in_ready}, 64'd0);
    reset = 1'b1;
    #1;
    check64("async_reset_in_ready", {63'd0, in_ready}, 64'd1);
    check64("async_reset_out_valid", {63'd0, out_valid}, 64'd0);
    check64("async_reset_out_result", out_result, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    expect_quiet("reset_no_result", 80);

    issue(3'd5, 1'b0, 64'd1000, 64'd7, 64'd142, 65, "divu_after_reset", 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
